regfile_wr_arbiter: RTL and testbench

- Shares the single register-file write port between several writeback requesters (ALU result, load data, branch-with-link).
- Round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning request and drives the 4-bit register select into the Dec4x16 write decoder, plus write enable and write data.
- Sits between the execute/memory writeback sources and the 16 x 32-bit register file.

---
 rtl/regfile_wr_arbiter_pkg.sv | 31 +++
 rtl/regfile_wr_arbiter_if.sv | 36 +++
 rtl/regfile_wr_arbiter_rr_pick.sv | 50 +++++
 rtl/regfile_wr_arbiter.sv | 90 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared constants and types for the register-file write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int REG_COUNT = 16;
    localparam int SEL_W     = 4;
    localparam int DATA_W    = 32;
    localparam int PC_IDX    = 15;

    localparam int REQ_ALU   = 0;
    localparam int REQ_LOAD  = 1;
    localparam int REQ_LINK  = 2;

    // Requester index width; wide enough for the largest legal NREQ (4).
    localparam int IDX_W     = 2;

    typedef logic [IDX_W-1:0] req_idx_t;

    // Increment with an explicit wrap so non-power-of-two NREQ rotates correctly.
    function automatic req_idx_t wrap_inc(input req_idx_t i, input int n);
        return (int'(i) == n - 1) ? '0 : i + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wr_arbiter_if.sv
// ============================================================================
// Module   : regfile_wr_arbiter_if
// Brief    : Writeback requester bus and register-file write port bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_wr_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
);
    logic                     hold;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*SEL_W-1:0]    req_sel;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     wr_en;
    logic [SEL_W-1:0]         wr_sel;
    logic [DATA_W-1:0]        wr_data;
    logic                     pc_wr;
    logic [1:0]               grant_id;

    modport master (
        output hold, req_valid, req_sel, req_data,
        input  req_ready, wr_en, wr_sel, wr_data, pc_wr, grant_id
    );

    modport slave (
        input  hold, req_valid, req_sel, req_data,
        output req_ready, wr_en, wr_sel, wr_data, pc_wr, grant_id
    );

endinterface

`default_nettype wire

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational rotate-priority picker starting the search at ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import regfile_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  req_idx_t        ptr,
    output logic [NREQ-1:0] grant,
    output req_idx_t        idx,
    output logic            any
);

    logic [3:0] w_req_pad;
    logic [3:0] w_gnt_pad;
    logic [2:0] w_sum;
    req_idx_t   w_cand;

    always_comb begin
        w_req_pad            = '0;
        w_req_pad[NREQ-1:0]  = req;
        w_gnt_pad            = '0;
        w_sum                = '0;
        w_cand               = '0;
        idx                  = '0;
        any                  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, ptr} + 3'(k);
            if (w_sum >= 3'(NREQ)) begin
                w_sum = w_sum - 3'(NREQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!any && w_req_pad[w_cand]) begin
                any               = 1'b1;
                idx               = w_cand;
                w_gnt_pad[w_cand] = 1'b1;
            end
        end
        grant = w_gnt_pad[NREQ-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// Module   : regfile_wr_arbiter
// Brief    : Round-robin arbiter sharing the register-file write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int SEL_W  = regfile_pkg::SEL_W,
    parameter int PC_IDX = regfile_pkg::PC_IDX
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wr_arbiter_if.slave  bus
);

    req_idx_t              r_ptr;
    logic                  r_wr_en;
    logic [SEL_W-1:0]      r_wr_sel;
    logic [DATA_W-1:0]     r_wr_data;
    logic                  r_pc_wr;
    req_idx_t              r_grant_id;

    logic [NREQ-1:0]       w_grant;
    req_idx_t              w_idx;
    logic                  w_any;
    logic                  w_ok;
    logic                  w_xfer;
    logic [SEL_W-1:0]      w_sel;
    logic [DATA_W-1:0]     w_data;

    rr_pick #(
        .NREQ  (NREQ)
    ) u_pick (
        .req   (bus.req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    // Ready is only ever raised on a valid requester, so a grant is a transfer.
    assign w_ok          = !reset && !bus.hold;
    assign w_xfer        = w_ok && w_any;
    assign bus.req_ready = w_ok ? w_grant : '0;

    always_comb begin
        w_sel  = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == req_idx_t'(i)) begin
                w_sel  = bus.req_sel[i*SEL_W +: SEL_W];
                w_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_sel   <= '0;
            r_wr_data  <= '0;
            r_pc_wr    <= 1'b0;
            r_grant_id <= '0;
        end else begin
            r_wr_en <= w_xfer;
            r_pc_wr <= w_xfer && (w_sel == SEL_W'(PC_IDX));
            if (w_xfer) begin
                r_wr_sel   <= w_sel;
                r_wr_data  <= w_data;
                r_grant_id <= w_idx;
                r_ptr      <= wrap_inc(w_idx, NREQ);
            end
        end
    end

    assign bus.wr_en    = r_wr_en;
    assign bus.wr_sel   = r_wr_sel;
    assign bus.wr_data  = r_wr_data;
    assign bus.pc_wr    = r_pc_wr;
    assign bus.grant_id = r_grant_id;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// Module   : tb_regfile_wr_arbiter
// Brief    : Directed and randomized bench against a behavioural arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;

    localparam int NREQ = 3;

    logic clk;
    logic reset;

    regfile_wr_arbiter_if #(.NREQ(NREQ), .DATA_W(32), .SEL_W(4)) bus ();

    regfile_wr_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus state per requester
    logic [NREQ-1:0] v;
    logic [3:0]      s [NREQ];
    logic [31:0]     d [NREQ];
    logic            rst_r;
    logic            hold_r;

    // Reference model state
    int          m_ptr;
    logic        m_wr_en;
    logic [3:0]  m_wr_sel;
    logic [31:0] m_wr_data;
    logic        m_pc_wr;
    int          m_gid;
    int          last_g;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick();
        if (rst_r || hold_r) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic apply();
        reset         = rst_r;
        bus.hold      = hold_r;
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_sel[i*4 +: 4]   = s[i];
            bus.req_data[i*32 +: 32] = d[i];
        end
    endtask

    // One clock: check the combinational grant, advance the model, check the registers.
    task automatic step();
        int         g;
        logic [2:0] er;
        apply();
        #1;
        g  = pick();
        er = (g >= 0) ? (3'b001 << g) : 3'b000;
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        @(posedge clk);
        if (rst_r) begin
            m_ptr = 0; m_wr_en = 0; m_wr_sel = 0; m_wr_data = 0; m_pc_wr = 0; m_gid = 0;
        end else if (g >= 0) begin
            m_wr_en   = 1;
            m_wr_sel  = s[g];
            m_wr_data = d[g];
            m_gid     = g;
            m_pc_wr   = (s[g] == 4'd15);
            m_ptr     = (g + 1) % NREQ;
        end else begin
            m_wr_en = 0;
            m_pc_wr = 0;
        end
        last_g = rst_r ? -1 : g;
        #1;
        chk("wr_en",    32'(bus.wr_en),    32'(m_wr_en));
        chk("wr_sel",   32'(bus.wr_sel),   32'(m_wr_sel));
        chk("wr_data",  bus.wr_data,       m_wr_data);
        chk("pc_wr",    32'(bus.pc_wr),    32'(m_pc_wr));
        chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
    endtask

    initial begin
        m_ptr = 0; m_wr_en = 0; m_wr_sel = 0; m_wr_data = 0; m_pc_wr = 0; m_gid = 0;
        last_g = -1;

        // Reset with all three requests valid
        rst_r = 1; hold_r = 0; v = 3'b111;
        s[0] = 4'd1; s[1] = 4'd2; s[2] = 4'd3;
        d[0] = 32'hAAAA_0000; d[1] = 32'hBBBB_0000; d[2] = 32'hCCCC_0000;
        step(); step();
        rst_r = 0;

        // Rotation 0,1,2,0 with all held valid
        for (int c = 0; c < 5; c++) step();
        chk("rot_sel_direct", 32'(bus.wr_sel), 32'd2);

        // Link requester alone writing the PC
        v = 3'b100; s[2] = 4'd15; d[2] = 32'h0000_8000;
        step();
        chk("pc_wr_direct", 32'(bus.pc_wr), 32'd1);
        v = 3'b000;
        step();

        // Move ptr to 1, then two requesters hit the same register
        v = 3'b001; s[0] = 4'd4; d[0] = 32'h1111_1111;
        step();
        v = 3'b011; s[0] = 4'd7; s[1] = 4'd7; d[0] = 32'h0000_00A0; d[1] = 32'h0000_00B1;
        step();
        chk("same_dst_first", bus.wr_data, 32'h0000_00B1);
        v = 3'b001;
        step();
        chk("same_dst_second", bus.wr_data, 32'h0000_00A0);
        v = 3'b000;
        step();

        // Hold for three cycles with requests pending, then resume
        v = 3'b111; hold_r = 1;
        step(); step(); step();
        hold_r = 0;
        step(); step();

        // Reset the cycle after a grant
        step();
        rst_r = 1; step();
        rst_r = 0; v = 3'b110; step(); step();

        // Randomized traffic with occasional hold, withdraw and reset
        for (int c = 0; c < 400; c++) begin
            if (last_g >= 0) v[last_g] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        v[i] = 1'b1;
                        s[i] = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
                        d[i] = $urandom;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    v[i] = 1'b0;
                end
            end
            hold_r = ($urandom_range(0, 7) == 0);
            rst_r  = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
